// File: rtl/riscv_writeback_pkg.sv
// Shared RV32I writeback definitions: load funct3 encodings and the W pipeline register layout.
package riscv_writeback_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned REG_ADDR_W   = 5;
    localparam int unsigned FUNCT3_W     = 3;
    localparam int unsigned OFFSET_W     = 2;

    localparam logic [FUNCT3_W-1:0] FUNCT3_LB  = 3'b000;
    localparam logic [FUNCT3_W-1:0] FUNCT3_LH  = 3'b001;
    localparam logic [FUNCT3_W-1:0] FUNCT3_LW  = 3'b010;
    localparam logic [FUNCT3_W-1:0] FUNCT3_LBU = 3'b100;
    localparam logic [FUNCT3_W-1:0] FUNCT3_LHU = 3'b101;

    typedef struct packed {
        logic                    valid;
        logic                    regWrEn;
        logic                    resultSrc;
        logic [FUNCT3_W-1:0]     funct3;
        logic [OFFSET_W-1:0]     offset;
        logic [XLEN_DEFAULT-1:0] readData;
        logic [XLEN_DEFAULT-1:0] wbData;
        logic [REG_ADDR_W-1:0]   rd;
    } wbReg_t;

endpackage

// File: rtl/riscv_load_extend.sv
// Load data extraction: selects the addressed byte/half/word and extends it,
// flagging offsets that are misaligned for the access size.
module riscv_load_extend
    import riscv_writeback_pkg::*;
#(
    parameter int unsigned XLEN = riscv_writeback_pkg::XLEN_DEFAULT
) (
    input  logic [FUNCT3_W-1:0] i_funct3,
    input  logic [OFFSET_W-1:0] i_offset,
    input  logic [XLEN-1:0]     i_word,
    output logic [XLEN-1:0]     o_data,
    output logic                o_misaligned
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    // Lane select: byte uses the full offset, half only its upper bit.
    always_comb begin
        byteSel = 8'(i_word >> {i_offset, 3'b000});
        halfSel = 16'(i_word >> {i_offset[1], 4'b0000});
    end

    always_comb begin
        o_data       = i_word;
        o_misaligned = 1'b0;
        case (i_funct3)
            FUNCT3_LB:  o_data = {{(XLEN-8){byteSel[7]}}, byteSel};
            FUNCT3_LBU: o_data = {{(XLEN-8){1'b0}}, byteSel};
            FUNCT3_LH: begin
                o_data       = {{(XLEN-16){halfSel[15]}}, halfSel};
                o_misaligned = i_offset[0];
            end
            FUNCT3_LHU: begin
                o_data       = {{(XLEN-16){1'b0}}, halfSel};
                o_misaligned = i_offset[0];
            end
            FUNCT3_LW:  o_misaligned = (i_offset != 2'b00);
            default:    o_data = i_word;
        endcase
    end

endmodule

// File: rtl/riscv_writeback.sv
// RV32I writeback stage: M->W pipeline register with stall/flush, load extension,
// regfile write port / W forwarding path, and retired-instruction counter.
module riscv_writeback
    import riscv_writeback_pkg::*;
#(
    parameter int unsigned XLEN  = riscv_writeback_pkg::XLEN_DEFAULT,
    parameter int unsigned CNT_W = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_validM,
    input  logic                  i_ctrl_reg_wr_enM,
    input  logic                  i_ctrl_result_srcM,
    input  logic [FUNCT3_W-1:0]   i_ctrl_funct3M,
    input  logic [XLEN-1:0]       i_alu_resultM,
    input  logic [XLEN-1:0]       i_mem_readdataM,
    input  logic [XLEN-1:0]       i_writeback_dataM,
    input  logic [REG_ADDR_W-1:0] i_regfile_rd_addrM,
    input  logic                  i_stallW,
    input  logic                  i_flushW,
    output logic                  o_validW,
    output logic                  o_regfile_wr_enW,
    output logic [REG_ADDR_W-1:0] o_regfile_rd_addrW,
    output logic [XLEN-1:0]       o_regfile_wr_dataW,
    output logic                  o_load_misalignW,
    output logic [CNT_W-1:0]      o_instret
);

    wbReg_t            wReg;
    logic [CNT_W-1:0]  instretQ;
    logic [XLEN-1:0]   loadData;
    logic              loadMisaligned;
    logic              misalignW;
    logic              retire;
    logic              unusedAddrBits;

    // Only the byte offset of the effective address matters past M.
    assign unusedAddrBits = ^i_alu_resultM[XLEN-1:OFFSET_W];

    // Flush wins over stall; a flushed W keeps its payload but cannot write.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wReg <= '0;
        end else if (i_flushW) begin
            wReg.valid   <= 1'b0;
            wReg.regWrEn <= 1'b0;
        end else if (!i_stallW) begin
            wReg.valid     <= i_validM;
            wReg.regWrEn   <= i_ctrl_reg_wr_enM;
            wReg.resultSrc <= i_ctrl_result_srcM;
            wReg.funct3    <= i_ctrl_funct3M;
            wReg.offset    <= i_alu_resultM[OFFSET_W-1:0];
            wReg.readData  <= i_mem_readdataM;
            wReg.wbData    <= i_writeback_dataM;
            wReg.rd        <= i_regfile_rd_addrM;
        end
    end

    assign retire = i_validM & ~i_flushW & ~i_stallW;

    // Counts every captured real instruction, misaligned loads included; wraps naturally.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            instretQ <= '0;
        end else if (retire) begin
            instretQ <= instretQ + CNT_W'(1);
        end
    end

    riscv_load_extend #(
        .XLEN(XLEN)
    ) u_load_extend (
        .i_funct3    (wReg.funct3),
        .i_offset    (wReg.offset),
        .i_word      (wReg.readData),
        .o_data      (loadData),
        .o_misaligned(loadMisaligned)
    );

    // x0 is never written and a misaligned load suppresses its own write.
    always_comb begin
        misalignW          = wReg.valid & wReg.resultSrc & loadMisaligned;
        o_validW           = wReg.valid;
        o_load_misalignW   = misalignW;
        o_regfile_rd_addrW = wReg.rd;
        o_regfile_wr_dataW = wReg.resultSrc ? loadData : wReg.wbData;
        o_regfile_wr_enW   = wReg.valid & wReg.regWrEn & (wReg.rd != '0) & ~misalignW;
        o_instret          = instretQ;
    end

endmodule

// File: tb/tb_riscv_writeback.sv
// Self-checking bench for riscv_writeback: vector table through a scoreboard queue,
// plus stall/flush, reset and counter-wrap sequences.
module tb_riscv_writeback;
    import riscv_writeback_pkg::*;

    localparam logic [31:0] RDATA = 32'h80FF_7F01;

    logic        clk = 1'b0;
    logic        rstn;
    logic        validM, regWrEnM, resultSrcM, stallW, flushW;
    logic [2:0]  funct3M;
    logic [31:0] aluResultM, readDataM, wbDataM;
    logic [4:0]  rdM;
    logic        validW, wrEnW, misW, validW4, wrEnW4, misW4;
    logic [4:0]  rdW, rdW4;
    logic [31:0] wrDataW, wrDataW4;
    logic [63:0] instret;
    logic [3:0]  instret4;

    always #5 clk = ~clk;

    riscv_writeback dut (
        .i_clk(clk), .i_rstn(rstn), .i_validM(validM), .i_ctrl_reg_wr_enM(regWrEnM),
        .i_ctrl_result_srcM(resultSrcM), .i_ctrl_funct3M(funct3M), .i_alu_resultM(aluResultM),
        .i_mem_readdataM(readDataM), .i_writeback_dataM(wbDataM), .i_regfile_rd_addrM(rdM),
        .i_stallW(stallW), .i_flushW(flushW), .o_validW(validW), .o_regfile_wr_enW(wrEnW),
        .o_regfile_rd_addrW(rdW), .o_regfile_wr_dataW(wrDataW), .o_load_misalignW(misW),
        .o_instret(instret)
    );

    riscv_writeback #(.CNT_W(4)) dut4 (
        .i_clk(clk), .i_rstn(rstn), .i_validM(validM), .i_ctrl_reg_wr_enM(regWrEnM),
        .i_ctrl_result_srcM(resultSrcM), .i_ctrl_funct3M(funct3M), .i_alu_resultM(aluResultM),
        .i_mem_readdataM(readDataM), .i_writeback_dataM(wbDataM), .i_regfile_rd_addrM(rdM),
        .i_stallW(stallW), .i_flushW(flushW), .o_validW(validW4), .o_regfile_wr_enW(wrEnW4),
        .o_regfile_rd_addrW(rdW4), .o_regfile_wr_dataW(wrDataW4), .o_load_misalignW(misW4),
        .o_instret(instret4)
    );

    typedef struct {
        logic        validM, wrEn, resSrc;
        logic [2:0]  f3;
        logic [31:0] addr, rdata, wbdata;
        logic [4:0]  rd;
        logic        eValid, eWrEn, eMis;
        logic [31:0] eData;
    } vec_t;

    typedef struct {
        logic        v, we, mis;
        logic [4:0]  rd;
        logic [31:0] d;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [63:0] instModel = '0;

    function automatic vec_t mk(logic v, logic we, logic rs, logic [2:0] f3, logic [31:0] addr,
                                logic [31:0] wbd, logic [4:0] rd,
                                logic ev, logic ewe, logic emis, logic [31:0] ed);
        vec_t t;
        t.validM = v; t.wrEn = we; t.resSrc = rs; t.f3 = f3; t.addr = addr;
        t.rdata = RDATA; t.wbdata = wbd; t.rd = rd;
        t.eValid = ev; t.eWrEn = ewe; t.eMis = emis; t.eData = ed;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkCounters(input string name);
        check({name, ".instret"}, instret, instModel);
        check({name, ".instret4"}, 64'(instret4), 64'(instModel[3:0]));
    endtask

    // Drive one M instruction, capture it, then compare W against the scoreboard.
    task automatic drive(input vec_t t);
        exp_t e;
        validM = t.validM; regWrEnM = t.wrEn; resultSrcM = t.resSrc; funct3M = t.f3;
        aluResultM = t.addr; readDataM = t.rdata; wbDataM = t.wbdata; rdM = t.rd;
        stallW = 1'b0; flushW = 1'b0;
        e.v = t.eValid; e.we = t.eWrEn; e.mis = t.eMis; e.rd = t.rd; e.d = t.eData;
        sb.push_back(e);
        if (t.validM) instModel++;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb.empty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check("validW", 64'(validW), 64'(e.v));
            check("wrEnW", 64'(wrEnW), 64'(e.we));
            check("misalignW", 64'(misW), 64'(e.mis));
            check("rdW", 64'(rdW), 64'(e.rd));
            check("wrDataW", 64'(wrDataW), 64'(e.d));
            checkCounters("drive");
        end
    endtask

    initial begin
        rstn = 1'b0; validM = 0; regWrEnM = 0; resultSrcM = 0; funct3M = '0;
        aluResultM = '0; readDataM = '0; wbDataM = '0; rdM = '0; stallW = 0; flushW = 0;
        #12;
        check("rst.validW", 64'(validW), 64'd0);
        check("rst.wrEnW", 64'(wrEnW), 64'd0);
        check("rst.wrDataW", 64'(wrDataW), 64'd0);
        checkCounters("rst");
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        vecs.push_back(mk(1, 1, 0, FUNCT3_LW,  32'h0,    32'h1234_5678, 5, 1, 1, 0, 32'h1234_5678));
        vecs.push_back(mk(1, 1, 1, FUNCT3_LB,  32'h1003, 32'h0,         1, 1, 1, 0, 32'hFFFF_FF80));
        vecs.push_back(mk(1, 1, 1, FUNCT3_LBU, 32'h1002, 32'h0,         2, 1, 1, 0, 32'h0000_00FF));
        vecs.push_back(mk(1, 1, 1, FUNCT3_LH,  32'h1002, 32'h0,         3, 1, 1, 0, 32'hFFFF_80FF));
        vecs.push_back(mk(1, 1, 1, FUNCT3_LHU, 32'h1000, 32'h0,         4, 1, 1, 0, 32'h0000_7F01));
        vecs.push_back(mk(1, 1, 1, FUNCT3_LW,  32'h1000, 32'h0,         6, 1, 1, 0, 32'h80FF_7F01));
        vecs.push_back(mk(1, 1, 1, FUNCT3_LW,  32'h1002, 32'h0,         8, 1, 0, 1, 32'h80FF_7F01));
        vecs.push_back(mk(1, 1, 1, FUNCT3_LH,  32'h1001, 32'h0,         9, 1, 0, 1, 32'h0000_7F01));
        vecs.push_back(mk(1, 1, 1, FUNCT3_LB,  32'h1001, 32'h0,        10, 1, 1, 0, 32'h0000_007F));
        vecs.push_back(mk(1, 1, 1, FUNCT3_LHU, 32'h1003, 32'h0,        11, 1, 0, 1, 32'h0000_80FF));
        vecs.push_back(mk(1, 1, 1, FUNCT3_LBU, 32'h1000, 32'h0,        12, 1, 1, 0, 32'h0000_0001));
        vecs.push_back(mk(1, 1, 1, 3'b011,     32'h1003, 32'h0,        13, 1, 1, 0, 32'h80FF_7F01));
        vecs.push_back(mk(1, 1, 0, FUNCT3_LW,  32'h1002, 32'hCAFE_0001,14, 1, 1, 0, 32'hCAFE_0001));
        vecs.push_back(mk(1, 1, 0, FUNCT3_LW,  32'h0,    32'h5555_AAAA, 0, 1, 0, 0, 32'h5555_AAAA));
        vecs.push_back(mk(0, 1, 0, FUNCT3_LW,  32'h0,    32'h0BAD_0BAD,15, 0, 0, 0, 32'h0BAD_0BAD));
        foreach (vecs[i]) drive(vecs[i]);

        // Stall with an rd=7 write pending: W holds, write enable stays up, no retirement.
        drive(mk(1, 1, 0, FUNCT3_LW, 32'h0, 32'h7777_7777, 7, 1, 1, 0, 32'h7777_7777));
        validM = 1; regWrEnM = 1; resultSrcM = 0; rdM = 5'd9; wbDataM = 32'hDEAD_BEEF;
        stallW = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("stall.validW", 64'(validW), 64'd1);
            check("stall.wrEnW", 64'(wrEnW), 64'd1);
            check("stall.rdW", 64'(rdW), 64'd7);
            check("stall.wrDataW", 64'(wrDataW), 64'h7777_7777);
            checkCounters("stall");
        end
        flushW = 1'b1;
        @(posedge clk);
        #1;
        check("flushstall.validW", 64'(validW), 64'd0);
        check("flushstall.wrEnW", 64'(wrEnW), 64'd0);
        check("flushstall.rdW", 64'(rdW), 64'd7);
        checkCounters("flushstall");
        stallW = 1'b0;
        @(posedge clk);
        #1;
        check("flush.validW", 64'(validW), 64'd0);
        check("flush.wrEnW", 64'(wrEnW), 64'd0);
        checkCounters("flush");
        flushW = 1'b0;

        // Enough captures to carry the 4-bit counter through its wrap.
        for (int k = 0; k < 20; k++)
            drive(mk(1, 1, 0, FUNCT3_LW, 32'h0, 32'(k) + 32'h100, 5'(k + 1), 1, 1, 0, 32'(k) + 32'h100));

        // Reset mid-cycle with a live write in W must clear outputs without a clock edge.
        drive(mk(1, 1, 0, FUNCT3_LW, 32'h0, 32'h3333_3333, 3, 1, 1, 0, 32'h3333_3333));
        #2;
        rstn = 1'b0;
        #1;
        instModel = '0;
        check("midrst.wrEnW", 64'(wrEnW), 64'd0);
        check("midrst.validW", 64'(validW), 64'd0);
        checkCounters("midrst");
        @(negedge clk);
        rstn = 1'b1;
        drive(mk(1, 1, 0, FUNCT3_LW, 32'h0, 32'h4444_4444, 4, 1, 1, 0, 32'h4444_4444));

        check("sb.drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_writeback.md
Name: riscv_writeback

Overview:
Writeback stage of the pipelined RV32I core. It sits directly downstream of the memory stage and owns the M->W pipeline register, with stall and flush control. It extracts and extends load data by funct3 and byte offset, selects the final register-file write data, and drives the regfile write port and the W-stage forwarding path. It also keeps a retired-instruction counter.

Parameters:
XLEN, `XLEN (32), datapath width, taken from the shared config.
CNT_W, 64, width of the retired-instruction counter.

Ports:
i_clk  input  1  core clock, rising edge.
i_rstn  input  1  asynchronous active-low reset.
i_validM  input  1  M stage holds a real instruction (not a bubble).
i_ctrl_reg_wr_enM  input  1  instruction writes rd.
i_ctrl_result_srcM  input  1  1 = load result, 0 = i_writeback_dataM.
i_ctrl_funct3M  input  3  load type.
i_alu_resultM  input  XLEN  effective address; bits [1:0] are the byte offset.
i_mem_readdataM  input  XLEN  raw aligned dmem word, valid combinationally in M.
i_writeback_dataM  input  XLEN  non-load result from the M-stage mux.
i_regfile_rd_addrM  input  5  destination register.
i_stallW  input  1  hold the W register.
i_flushW  input  1  insert a bubble into W.
o_validW  output  1  W holds a real instruction.
o_regfile_wr_enW  output  1  regfile write enable.
o_regfile_rd_addrW  output  5  regfile write address; also the forwarding tag.
o_regfile_wr_dataW  output  XLEN  regfile write data; also the forwarding data.
o_load_misalignW  output  1  W holds a misaligned load.
o_instret  output  CNT_W  count of retired instructions.

Behaviour:
- Reset is asynchronous, active-low: one clock, i_clk; one reset, i_rstn.
- Reset values: all W registers and o_instret = 0. All outputs are therefore 0 during reset.
- A reset asserted mid-operation discards the W contents immediately.
- W register update, at each rising edge:
  - i_flushW=1 (takes priority over stall): validW<=0, reg_wr_enW<=0, all other fields hold.
  - else i_stallW=1: all fields hold.
  - else: capture all M inputs. Captured fields are valid, reg_wr_en, result_src, funct3, addr[1:0], readdata, writeback_data and rd.
- Latency: M inputs appear at W outputs 1 cycle later. All W outputs are combinational from the W register.
- Load extraction, combinational in W, with off = addr[1:0]:
  - LB (000): sign-extend readdata[off*8 +: 8].
  - LBU (100): zero-extend readdata[off*8 +: 8].
  - LH (001): sign-extend readdata[off[1]*16 +: 16]; misaligned if off[0]=1.
  - LHU (101): zero-extend readdata[off[1]*16 +: 16]; misaligned if off[0]=1.
  - LW (010): the whole word; misaligned if off!=0.
  - Any other funct3: pass the raw word, never flagged misaligned.
- o_load_misalignW = validW & result_srcW & misaligned.
- o_regfile_wr_dataW = result_srcW ? extended load : writeback_dataW.
- o_regfile_wr_enW = validW & reg_wr_enW & (rd!=0) & ~o_load_misalignW.
  - x0 is never written.
  - A misaligned load suppresses the write and raises o_load_misalignW for as long as it sits in W.
- Stall with a write pending: the write enable stays high. Rewriting the same rd/data is harmless and keeps forwarding valid.
- o_instret:
  - Increments by 1 on each edge where the W register captures with i_validM=1, i_flushW=0 and i_stallW=0.
  - Misaligned loads are counted.
  - Wraps from 2^CNT_W-1 to 0.
  - A simultaneous flush or stall blocks the increment.

Decomposition:
- Load funct3 constants (FUNCT3_LB/LH/LW/LBU/LHU) go into the shared riscv_configs definitions.
- One combinational sub-module, riscv_load_extend. Inputs: funct3, offset, word. Outputs: data and misaligned flag.
- The pipeline register, result mux and counter stay in riscv_writeback.

Test Plan:
1. Reset mid-run with a valid write in W, i_rstn=0 -> o_regfile_wr_enW=0, o_instret=0 immediately, without waiting for a clock edge.
2. ALU op: rd=5, data=0x1234_5678, reg_wr_en=1, result_src=0 -> next cycle wr_en=1, addr=5, data=0x1234_5678, o_instret +1.
3. Loads from readdata=0x80FF_7F01:
   - LB, off=3 -> 0xFFFF_FF80.
   - LBU, off=2 -> 0x0000_00FF.
   - LH, off=2 -> 0xFFFF_80FF.
   - LHU, off=0 -> 0x0000_7F01.
   - LW, off=0 -> 0x80FF_7F01.
4. LW at addr 0x...02 -> o_load_misalignW=1, wr_en=0. LH at off=1 -> misaligned. LB at off=1 -> accepted.
5. Stall 3 cycles with an rd=7 write in W -> outputs held for 3 cycles, wr_en high throughout, o_instret unchanged. Then flush+stall together -> o_validW=0, wr_en=0.
6. rd=0 with reg_wr_en=1 -> wr_en=0, instret still counts. With CNT_W=4, counter at 15 plus one valid capture -> 0.
